// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, xtime, Rcon seed, legal
// parameter triples and the key-expansion FSM state type.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Row-major S-box, entry 0 in the top byte
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[2047 - 8*int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit legal_params(input int key_len, input int nr, input int nk);
        return (key_len == 128 && nr == 10 && nk == 4) ||
               (key_len == 192 && nr == 12 && nk == 6) ||
               (key_len == 256 && nr == 14 && nk == 8);
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Start/busy/valid handshake and round-key bus between key-schedule generator and its user.
interface aes_key_expand_seq_if #(
    parameter int KEY_LEN = 128,
    parameter int NR      = 10
);
    logic                      start_i;
    logic [KEY_LEN-1:0]        key_i;
    logic                      busy_o;
    logic                      valid_o;
    logic [128*(NR+1)-1:0]     round_keys_o;

    modport master (
        output start_i, key_i,
        input  busy_o, valid_o, round_keys_o
    );

    modport slave (
        input  start_i, key_i,
        output busy_o, valid_o, round_keys_o
    );
endinterface

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sbox_word
    import aes_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                     sbox(i_word[15:8]),  sbox(i_word[7:0])};
endmodule

// File: rtl/aes_key_expand_seq.sv
// Sequential FIPS-197 key schedule: one 32-bit word per clock through a single
// SubWord path, full schedule held on a flat bus until the next accepted key.
module aes_key_expand_seq
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 128,
    parameter int NR      = 10,
    parameter int NK      = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_key_expand_seq_if.slave bus
);
    localparam int NW = 4*(NR+1);
    localparam int IW = 6;

    generate
        if (!legal_params(KEY_LEN, NR, NK)) begin : g_bad_params
            $error("aes_key_expand_seq: illegal (KEY_LEN, NR, NK) triple");
        end
    endgenerate

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_w [NW];
    logic [IW-1:0]  r_i;
    logic [2:0]     r_m;
    logic [7:0]     r_rcon;

    logic           w_accept;
    logic [31:0]    w_prev;
    logic [31:0]    w_back;
    logic [31:0]    w_sub_in;
    logic [31:0]    w_sub_out;
    logic [31:0]    w_temp;
    logic [31:0]    w_new;

    // A start during EXPAND is deliberately invisible to both FSM and datapath
    assign w_accept = bus.start_i && (r_state != EXPAND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (w_accept) w_state_nxt = EXPAND;
            EXPAND:     if (r_i == IW'(NW-1)) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    assign w_prev   = r_w[r_i - 1'b1];
    assign w_back   = r_w[r_i - IW'(NK)];
    assign w_sub_in = (r_m == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    aes_sbox_word u_sbox (
        .i_word (w_sub_in),
        .o_word (w_sub_out)
    );

    always_comb begin
        w_temp = w_prev;
        if (r_m == 3'd0)
            w_temp = w_sub_out ^ {r_rcon, 24'h0};
        else if (NK > 6 && r_m == 3'd4)
            w_temp = w_sub_out;
    end

    assign w_new = w_back ^ w_temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NW; j++) r_w[j] <= '0;
            r_i    <= '0;
            r_m    <= '0;
            r_rcon <= RCON_INIT;
        end else if (w_accept) begin
            for (int j = 0; j < NK; j++) r_w[j] <= bus.key_i[KEY_LEN-1-32*j -: 32];
            r_i    <= IW'(NK);
            r_m    <= '0;
            r_rcon <= RCON_INIT;
        end else if (r_state == EXPAND) begin
            r_w[r_i] <= w_new;
            r_i      <= r_i + 1'b1;
            r_m      <= (r_m == 3'(NK-1)) ? 3'd0 : r_m + 3'd1;
            if (r_m == 3'd0) r_rcon <= xtime(r_rcon);
        end
    end

    assign bus.busy_o  = (r_state == EXPAND);
    assign bus.valid_o = (r_state == DONE);

    generate
        for (genvar j = 0; j < NW; j++) begin : g_flat
            assign bus.round_keys_o[32*(NW-j)-1 -: 32] = r_w[j];
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Scoreboard bench for aes_key_expand_seq: AES-128/192/256 instances with FIPS-197 vectors.
module tb_aes_key_expand_seq;

    localparam logic [255:0] K128A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K128B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RK128A = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] RK128B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192  = 128'ha4970a331a78dc09c418c271e3a41d5d;
    localparam logic [127:0] RK256  = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_key_expand_seq_if #(.KEY_LEN(128), .NR(10)) if128 ();
    aes_key_expand_seq_if #(.KEY_LEN(192), .NR(12)) if192 ();
    aes_key_expand_seq_if #(.KEY_LEN(256), .NR(14)) if256 ();

    aes_key_expand_seq #(.KEY_LEN(128), .NR(10), .NK(4)) u128 (.clk(clk), .rst_n(rst_n), .bus(if128));
    aes_key_expand_seq #(.KEY_LEN(192), .NR(12), .NK(6)) u192 (.clk(clk), .rst_n(rst_n), .bus(if192));
    aes_key_expand_seq #(.KEY_LEN(256), .NR(14), .NK(8)) u256 (.clk(clk), .rst_n(rst_n), .bus(if256));

    typedef struct {
        logic [127:0] rk0;
        logic [127:0] rkl;
        int           lat;
        int           t0;
    } item_t;

    item_t sbq [3][$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    bit    pv [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic v, input logic [127:0] rk0, input logic [127:0] rkl);
        item_t it;
        if (v && !pv[d]) begin
            if (sbq[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid dut%0d: got valid_o=1 expected no schedule", d);
            end else begin
                it = sbq[d].pop_front();
                chk($sformatf("rk0_dut%0d", d), 256'(rk0), 256'(it.rk0));
                chk($sformatf("rklast_dut%0d", d), 256'(rkl), 256'(it.rkl));
                chk($sformatf("latency_dut%0d", d), 256'(cyc - it.t0), 256'(it.lat));
            end
        end
        pv[d] = v;
    endtask

    // Monitor: compares each newly presented schedule with the oldest expectation
    always @(negedge clk) begin
        mon(0, if128.valid_o, if128.round_keys_o[1407 -: 128], if128.round_keys_o[127:0]);
        mon(1, if192.valid_o, if192.round_keys_o[1663 -: 128], if192.round_keys_o[127:0]);
        mon(2, if256.valid_o, if256.round_keys_o[1919 -: 128], if256.round_keys_o[127:0]);
    end

    task automatic drive(input int d, input logic [255:0] key, input logic s);
        case (d)
            0: begin if128.start_i = s; if128.key_i = key[255:128]; end
            1: begin if192.start_i = s; if192.key_i = key[255:64];  end
            default: begin if256.start_i = s; if256.key_i = key; end
        endcase
    endtask

    task automatic issue(input int d, input logic [255:0] key, input logic [127:0] rkl, input int lat);
        item_t it;
        it.rk0 = key[255:128];
        it.rkl = rkl;
        it.lat = lat;
        it.t0  = cyc;
        sbq[d].push_back(it);
        drive(d, key, 1'b1);
    endtask

    task automatic wait_q(input int d, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (sbq[d].size() == 0) return;
            @(negedge clk); #1;
        end
        checks++;
        errors++;
        $display("FAIL timeout dut%0d: got no valid_o within %0d cycles expected one", d, budget);
        sbq[d].delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

    initial begin
        drive(0, '0, 1'b0);
        drive(1, '0, 1'b0);
        drive(2, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset_busy128",  256'(if128.busy_o),  256'(0));
        chk("reset_valid128", 256'(if128.valid_o), 256'(0));
        chk("reset_rk128",    256'(if128.round_keys_o == '0), 256'(1));
        chk("reset_busy192",  256'(if192.busy_o),  256'(0));
        chk("reset_valid192", 256'(if192.valid_o), 256'(0));
        chk("reset_rk192",    256'(if192.round_keys_o == '0), 256'(1));
        chk("reset_busy256",  256'(if256.busy_o),  256'(0));
        chk("reset_valid256", 256'(if256.valid_o), 256'(0));
        chk("reset_rk256",    256'(if256.round_keys_o == '0), 256'(1));
        rst_n = 1'b1;
        @(negedge clk); #1;

        // All three key sizes in parallel; key_i is scrambled right after acceptance
        issue(0, K128A, RK128A, 41);
        issue(1, K192,  RK192,  47);
        issue(2, K256,  RK256,  53);
        @(negedge clk); #1;
        chk("busy_after_start128", 256'(if128.busy_o), 256'(1));
        chk("busy_after_start192", 256'(if192.busy_o), 256'(1));
        chk("busy_after_start256", 256'(if256.busy_o), 256'(1));
        drive(0, '1, 1'b0);
        drive(1, '1, 1'b0);
        drive(2, '1, 1'b0);
        wait_q(0, 100);
        wait_q(1, 100);
        wait_q(2, 100);
        chk("busy_done128", 256'(if128.busy_o), 256'(0));

        // Second key with a stray start carrying a different key mid-expansion
        issue(0, K128B, RK128B, 41);
        @(negedge clk); #1;
        drive(0, '1, 1'b0);
        repeat (5) @(negedge clk);
        #1;
        drive(0, K128A, 1'b1);
        @(negedge clk); #1;
        drive(0, '0, 1'b0);
        wait_q(0, 100);
        chk("w43_128b", 256'(if128.round_keys_o[31:0]), 256'(32'hb6630ca6));

        // Restart directly from DONE
        issue(0, K128A, RK128A, 41);
        @(negedge clk); #1;
        chk("restart_valid_drop", 256'(if128.valid_o), 256'(0));
        chk("restart_busy",       256'(if128.busy_o),  256'(1));
        drive(0, '1, 1'b0);
        wait_q(0, 100);

        // Asynchronous reset in the middle of an expansion
        issue(0, K128B, RK128B, 41);
        @(negedge clk); #1;
        drive(0, '1, 1'b0);
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy128",  256'(if128.busy_o),  256'(0));
        chk("midrst_valid128", 256'(if128.valid_o), 256'(0));
        chk("midrst_rk128",    256'(if128.round_keys_o == '0), 256'(1));
        chk("midrst_valid256", 256'(if256.valid_o), 256'(0));
        chk("midrst_rk256",    256'(if256.round_keys_o == '0), 256'(1));
        sbq[0].delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("postrst_idle_busy",  256'(if128.busy_o),  256'(0));
        chk("postrst_idle_valid", 256'(if128.valid_o), 256'(0));
        issue(0, K128B, RK128B, 41);
        @(negedge clk); #1;
        drive(0, '1, 1'b0);
        wait_q(0, 100);
        chk("postrst_w43", 256'(if128.round_keys_o[31:0]), 256'(32'hb6630ca6));

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
